// File: rtl/pipe_ctrl_n_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_n_if
// Purpose  : Request/control bundle between the core and the pipeline
//            sequencer. The master side raises stage requests, the slave
//            (sequencer) returns keep/dirty controls and counters.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_n_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
);
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] extend;
  logic [STAGES-1:0] flush;
  logic              freeze;
  logic              drain_req;
  logic              cnt_clr;
  logic [STAGES-1:0] keep;
  logic [STAGES-1:0] dirty;
  logic              drained;
  logic [CNT_W-1:0]  retired;
  logic [CNT_W-1:0]  bubbles;

  modport master (
    output stall, extend, flush, freeze, drain_req, cnt_clr,
    input  keep, dirty, drained, retired, bubbles
  );

  modport slave (
    input  stall, extend, flush, freeze, drain_req, cnt_clr,
    output keep, dirty, drained, retired, bubbles
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_n
// Purpose  : Parametrised pipeline sequencer. Converts per-stage stall,
//            extend and flush requests into per-stage keep (hold) and dirty
//            (bubble) controls, with global freeze, a drain handshake and
//            saturating retire/bubble counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl_n #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pipe_ctrl_n_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_state_nx;
  logic [STAGES-1:0] w_req;
  logic [STAGES-1:0] w_keep;
  logic [STAGES-1:0] w_dirty_nx;
  logic [STAGES-1:0] r_dirty;
  logic              r_drained;
  logic              w_drain_active;
  logic              w_exit;
  logic              w_exit_valid;
  logic [CNT_W-1:0]  r_retired;
  logic [CNT_W-1:0]  r_bubbles;

  assign w_req          = bus.stall | bus.extend;
  assign w_drain_active = (r_state != RUN) | bus.drain_req;

  // A hold in stage i also holds every older stage (lower index); younger
  // stages keep flowing. The dirty next-state is resolved per stage here.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      assign w_keep[g] = bus.freeze | (|w_req[STAGES-1:g]);

      if (g == 0) begin : g_fetch
        // Fetch loads a valid slot unless it is squashed or issue is stopped.
        assign w_dirty_nx[g] = w_keep[g] ? (r_dirty[g] | bus.flush[g])
                                         : (bus.flush[g] | w_drain_active);
      end else begin : g_body
        // A held upstream stage sends a bubble; a squashed one moves as a bubble.
        assign w_dirty_nx[g] = w_keep[g] ? (r_dirty[g] | bus.flush[g])
                                         : (r_dirty[g-1] | bus.flush[g-1] | w_keep[g-1]);
      end
    end
  endgenerate

  // Slot leaves the last stage on any edge where it is not held.
  assign w_exit       = ~w_keep[STAGES-1] & ~bus.freeze;
  assign w_exit_valid = ~r_dirty[STAGES-1] & ~bus.flush[STAGES-1];

  // Drain FSM next-state: abandoning a drain takes priority over completing it.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      RUN:     if (bus.drain_req) w_state_nx = DRAIN;
      DRAIN:   if (!bus.drain_req) w_state_nx = RUN;
               else if (&r_dirty) w_state_nx = IDLE;
      IDLE:    if (!bus.drain_req) w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  // State, dirty and drained registers; drained mirrors residency in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_dirty   <= '1;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_dirty   <= w_dirty_nx;
      r_drained <= (w_state_nx == IDLE);
    end
  end

  // Saturating exit counters; clear overrides any increment on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired <= '0;
      r_bubbles <= '0;
    end else if (bus.cnt_clr) begin
      r_retired <= '0;
      r_bubbles <= '0;
    end else if (w_exit) begin
      if (w_exit_valid) begin
        if (r_retired != CNT_MAX) r_retired <= r_retired + 1'b1;
      end else begin
        if (r_bubbles != CNT_MAX) r_bubbles <= r_bubbles + 1'b1;
      end
    end
  end

  assign bus.keep    = w_keep;
  assign bus.dirty   = r_dirty;
  assign bus.drained = r_drained;
  assign bus.retired = r_retired;
  assign bus.bubbles = r_bubbles;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
Parametrised pipeline sequencing unit for the CPU core, generalising the fixed 5-stage keep/dirty controller to STAGES stages. It turns per-stage stall/flush/extend requests into per-stage keep (hold) and dirty (bubble) controls. New features:
- global freeze
- drain/drained handshake for halt, interrupt entry and debug
- saturating retire and bubble performance counters

Parameters:
STAGES, 5, number of pipeline stages; bit 0 = first stage (fetch), bit STAGES-1 = last stage (writeback); legal 2..16
CNT_W, 16, width of each performance counter; legal 4..32

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STAGES  stage i cannot advance this cycle (hazard)
extend  in  STAGES  stage i needs another cycle (multi-cycle op); same hold effect as stall
flush  in  STAGES  squash the instruction currently in stage i
freeze  in  1  hold the entire pipeline; no stage advances
drain_req  in  1  stop issue and empty the pipeline; level, held until released
cnt_clr  in  1  synchronous clear of both counters
keep  out  STAGES  stage i register holds its content this cycle (combinational)
dirty  out  STAGES  stage i register holds a bubble (registered)
drained  out  1  pipeline empty and issue stopped (registered)
retired  out  CNT_W  count of valid instructions leaving the last stage
bubbles  out  CNT_W  count of bubbles/squashed slots leaving the last stage

Behaviour:
- Reset (rst=0, async):
  - dirty = all ones
  - retired = bubbles = 0
  - drained = 0
  - FSM = RUN
  - keep is combinational and is not forced by reset.
- req[i] = stall[i] | extend[i].
- keep[i] = freeze | OR(req[j] for j >= i): a hold propagates to all older stages; younger stages keep flowing.
- dirty next-state per edge, flush has priority:
  - keep[i]=1: dirty[i] <= dirty[i] | flush[i].
  - keep[i]=0, i>0: dirty[i] <= dirty[i-1] | flush[i-1] | keep[i-1]. A hold upstream inserts a bubble; a squashed instruction moves forward as a bubble.
  - keep[i]=0, i=0: dirty[0] <= flush[0] | drain_active. Fetch always loads a valid slot unless squashed or draining.
- freeze=1: dirty bits change only by the flush OR; counters do not increment; the FSM still advances.
- FSM with states RUN, DRAIN, IDLE; drain_active = (state != RUN) | drain_req:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> IDLE when dirty is all ones; drained <= 1 on that same edge.
  - DRAIN -> RUN when drain_req=0; drained stays 0.
  - IDLE holds with drained=1 while drain_req=1.
  - IDLE -> RUN when drain_req=0; drained <= 0 on the same edge. Fetch issues valid again from the next load.
- Last-stage exit event, counted on an edge where keep[STAGES-1]=0 and freeze=0:
  - dirty[STAGES-1]=0 and flush[STAGES-1]=0: retired += 1.
  - otherwise: bubbles += 1.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces both counters to 0 that edge, overriding any increment.
- Flush and stall on the same stage: the stage holds (keep=1) and becomes dirty. The downstream stage still receives a bubble.
- Flushing an already-dirty stage has no effect; it is not an error.

Test Plan (STAGES=5, CNT_W=4 unless noted):
1. Release rst, all requests 0 -> dirty goes 11111 -> 11110 -> 11100 -> 11000 -> 10000 -> 00000 (bit 0 first) over 5 edges; bubbles=5; retired=1 after edge 6.
2. Full pipe, stall[1]=1 for one cycle -> keep=00011 (bits 1,0 set); next edge dirty=00100 (only bit 2); the bubble then walks out and bubbles increments by 1 four edges later.
3. Full pipe, flush[2]=1 together with stall[1]=1 -> keep=00011; next edge dirty bits 2 and 3 set, all others 0.
4. Full pipe, drain_req=1 held -> dirty[0] set at edge 1 and all ones at edge 5; drained=1 at edge 6; drain_req=0 -> drained=0 next edge and dirty[0] clears on the following edge.
5. Run 20 valid instructions, then cnt_clr=1 for one edge -> retired saturates at 15 (not 4); after the clr edge retired=0 and bubbles=0; freeze=1 for 3 cycles -> counters and dirty unchanged.
6. Drive rst=0 between edges mid-stream -> dirty=11111, counters=0 and drained=0 immediately without a clock edge; FSM returns to RUN.
